// File: rtl/nbout_pkg.sv
// nbout_pkg: constants shared by the NBout buffer and the NFU pipeline.
//   DEF_BIT_WIDTH / DEF_TN : default neuron width and neurons per entry
//   VEC_W                  : width of one Tn-wide entry vector
//   ST_*                   : drain FSM state encoding
package nbout_pkg;

    localparam int DEF_BIT_WIDTH = 16;
    localparam int DEF_TN        = 16;
    localparam int VEC_W         = DEF_BIT_WIDTH * DEF_TN;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SCAN    = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/nbout_mem.sv
// nbout_mem: DEPTH x VEC_W register array, one write port, two read ports.
//   clk, rst              : clock, async active-high reset (reload register only)
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr/rd_data : registered reload port, latency 1, holds when idle,
//                           same-cycle write to the read address is bypassed
//   drain_addr/drain_data : combinational drain read port
module nbout_mem
    import nbout_pkg::*;
#(
    parameter int W_VEC  = VEC_W,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [W_VEC-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [W_VEC-1:0]  rd_data,
    input  logic [ADDR_W-1:0] drain_addr,
    output logic [W_VEC-1:0]  drain_data
);

    logic [W_VEC-1:0] mem [DEPTH];

    // Storage itself is not reset; contents are undefined after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            if (wr_en && (wr_addr == rd_addr)) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= mem[rd_addr];
            end
        end
    end

    assign drain_data = mem[drain_addr];

endmodule

// File: rtl/nbout_buffer.sv
// nbout_buffer: output neuron buffer behind the NFU pipeline NBout interface.
//   clk, rst                        : clock, async active-high reset
//   i_wr_*                          : pipeline writes (partial or final)
//   i_rd_en/i_rd_addr, o_rd_*       : partial-sum reload, latency 1
//   i_drain_start/i_drain_count     : drain entries 0..count-1 in order
//   o_dma_*, i_dma_ready            : valid/ready drain stream
//   o_drain_done, o_busy            : drain completion pulse / in progress
//   o_err                           : sticky overwrite error
module nbout_buffer
    import nbout_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int Tn        = DEF_TN,
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_wr_en,
    input  logic [ADDR_W-1:0]       i_wr_addr,
    input  logic [BIT_WIDTH*Tn-1:0] i_wr_data,
    input  logic                    i_wr_final,
    input  logic                    i_rd_en,
    input  logic [ADDR_W-1:0]       i_rd_addr,
    output logic [BIT_WIDTH*Tn-1:0] o_rd_data,
    output logic                    o_rd_valid,
    input  logic                    i_drain_start,
    input  logic [ADDR_W:0]         i_drain_count,
    output logic [BIT_WIDTH*Tn-1:0] o_dma_data,
    output logic [ADDR_W-1:0]       o_dma_addr,
    output logic                    o_dma_valid,
    input  logic                    i_dma_ready,
    output logic                    o_drain_done,
    output logic                    o_busy,
    output logic                    o_err
);

    localparam int VW = BIT_WIDTH * Tn;

    logic [1:0]        state;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   idx_inc;
    logic [ADDR_W-1:0] idx_lo;
    logic [DEPTH-1:0]  flags;
    logic [VW-1:0]     drain_data;
    logic              handshake;

    assign idx_inc   = idx + {{ADDR_W{1'b0}}, 1'b1};
    assign idx_lo    = idx[ADDR_W-1:0];
    assign handshake = (state == ST_PRESENT) && i_dma_ready;

    assign o_dma_valid  = (state == ST_PRESENT);
    assign o_busy       = (state == ST_SCAN) || (state == ST_PRESENT);
    assign o_drain_done = (state == ST_DONE);

    nbout_mem #(
        .W_VEC  (VW),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (i_wr_en),
        .wr_addr    (i_wr_addr),
        .wr_data    (i_wr_data),
        .rd_en      (i_rd_en),
        .rd_addr    (i_rd_addr),
        .rd_data    (o_rd_data),
        .drain_addr (idx_lo),
        .drain_data (drain_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= i_rd_en;
        end
    end

    // Write is applied after the handshake clear so a same-cycle final write wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= '0;
        end else begin
            if (handshake) begin
                flags[idx_lo] <= 1'b0;
            end
            if (i_wr_en) begin
                flags[i_wr_addr] <= i_wr_final;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_err <= 1'b0;
        end else if (i_wr_en && (flags[i_wr_addr] ||
                                 (o_dma_valid && (i_wr_addr == o_dma_addr)))) begin
            o_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            count      <= '0;
            o_dma_data <= '0;
            o_dma_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_drain_start) begin
                        count <= i_drain_count;
                        idx   <= '0;
                        state <= (i_drain_count == '0) ? ST_DONE : ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (flags[idx_lo]) begin
                        o_dma_data <= drain_data;
                        o_dma_addr <= idx_lo;
                        state      <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (i_dma_ready) begin
                        idx   <= idx_inc;
                        state <= (idx_inc == count) ? ST_DONE : ST_SCAN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nbout_buffer.sv
module tb_nbout_buffer;

    localparam int BW = 16;
    localparam int TN = 16;
    localparam int AW = 6;
    localparam int VW = BW * TN;

    logic          clk;
    logic          rst;
    logic          i_wr_en;
    logic [AW-1:0] i_wr_addr;
    logic [VW-1:0] i_wr_data;
    logic          i_wr_final;
    logic          i_rd_en;
    logic [AW-1:0] i_rd_addr;
    logic [VW-1:0] o_rd_data;
    logic          o_rd_valid;
    logic          i_drain_start;
    logic [AW:0]   i_drain_count;
    logic [VW-1:0] o_dma_data;
    logic [AW-1:0] o_dma_addr;
    logic          o_dma_valid;
    logic          i_dma_ready;
    logic          o_drain_done;
    logic          o_busy;
    logic          o_err;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int done_ref;

    nbout_buffer #(
        .BIT_WIDTH (BW),
        .Tn        (TN),
        .DEPTH     (64),
        .ADDR_W    (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_wr_en       (i_wr_en),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .i_wr_final    (i_wr_final),
        .i_rd_en       (i_rd_en),
        .i_rd_addr     (i_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_rd_valid    (o_rd_valid),
        .i_drain_start (i_drain_start),
        .i_drain_count (i_drain_count),
        .o_dma_data    (o_dma_data),
        .o_dma_addr    (o_dma_addr),
        .o_dma_valid   (o_dma_valid),
        .i_dma_ready   (i_dma_ready),
        .o_drain_done  (o_drain_done),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_drain_done === 1'b1) done_cnt++;
    end

    typedef struct {
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [15:0]   wr_lane;
        logic          wr_final;
        logic          rd_en;
        logic [AW-1:0] rd_addr;
        logic          exp_valid;
        logic [15:0]   exp_lane;
        logic          exp_err;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [VW-1:0] rep(input logic [15:0] lane);
        return {TN{lane}};
    endfunction

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_one(input logic [AW-1:0] a, input logic [VW-1:0] d, input logic fin);
        i_wr_en    = 1'b1;
        i_wr_addr  = a;
        i_wr_data  = d;
        i_wr_final = fin;
        step();
        i_wr_en    = 1'b0;
    endtask

    task automatic start_drain(input logic [AW:0] cnt);
        i_drain_count = cnt;
        i_drain_start = 1'b1;
        step();
        i_drain_start = 1'b0;
    endtask

    task automatic wait_valid(input int max, input string name);
        int n = 0;
        while (o_dma_valid !== 1'b1 && n < max) begin
            step();
            n++;
        end
        check(name, VW'(o_dma_valid), VW'(1));
    endtask

    task automatic accept();
        i_dma_ready = 1'b1;
        step();
        i_dma_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 6'd5, 16'h0001, 1'b0, 1'b0, 6'd0, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 6'd0, 16'h0000, 1'b0, 1'b1, 6'd5, 1'b1, 16'h0001, 1'b0};
        vecs[2] = '{1'b0, 6'd0, 16'h0000, 1'b0, 1'b0, 6'd0, 1'b0, 16'h0001, 1'b0};
        vecs[3] = '{1'b1, 6'd5, 16'h00AA, 1'b0, 1'b1, 6'd5, 1'b1, 16'h00AA, 1'b0};
        vecs[4] = '{1'b0, 6'd0, 16'h0000, 1'b0, 1'b1, 6'd5, 1'b1, 16'h00AA, 1'b0};
        vecs[5] = '{1'b1, 6'd7, 16'h1234, 1'b0, 1'b1, 6'd5, 1'b1, 16'h00AA, 1'b0};
        vecs[6] = '{1'b0, 6'd0, 16'h0000, 1'b0, 1'b1, 6'd7, 1'b1, 16'h1234, 1'b0};

        rst = 1'b1;
        i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0; i_wr_final = 1'b0;
        i_rd_en = 1'b0; i_rd_addr = '0;
        i_drain_start = 1'b0; i_drain_count = '0; i_dma_ready = 1'b0;
        step();
        step();
        check("rst_rd_valid", VW'(o_rd_valid), '0);
        check("rst_rd_data", o_rd_data, '0);
        check("rst_dma_valid", VW'(o_dma_valid), '0);
        check("rst_busy", VW'(o_busy), '0);
        check("rst_done", VW'(o_drain_done), '0);
        check("rst_err", VW'(o_err), '0);
        rst = 1'b0;
        step();

        // Reload port vectors
        for (int i = 0; i < 7; i++) begin
            i_wr_en    = vecs[i].wr_en;
            i_wr_addr  = vecs[i].wr_addr;
            i_wr_data  = rep(vecs[i].wr_lane);
            i_wr_final = vecs[i].wr_final;
            i_rd_en    = vecs[i].rd_en;
            i_rd_addr  = vecs[i].rd_addr;
            step();
            check($sformatf("vec%0d_rd_valid", i), VW'(o_rd_valid), VW'(vecs[i].exp_valid));
            check($sformatf("vec%0d_rd_data", i), o_rd_data, rep(vecs[i].exp_lane));
            check($sformatf("vec%0d_err", i), VW'(o_err), VW'(vecs[i].exp_err));
        end
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;

        // Drain with backpressure, plus an ignored start while busy
        for (int a = 0; a < 4; a++) wr_one(AW'(a), rep(16'(a)), 1'b1);
        done_ref = done_cnt;
        start_drain(7'd4);
        check("bp_busy", VW'(o_busy), VW'(1));
        for (int e = 0; e < 4; e++) begin
            wait_valid(4, $sformatf("bp_valid%0d", e));
            check($sformatf("bp_addr%0d", e), VW'(o_dma_addr), VW'(e));
            check($sformatf("bp_data%0d", e), o_dma_data, rep(16'(e)));
            if (e == 1) begin
                i_drain_start = 1'b1;
                i_drain_count = 7'd0;
                step();
                i_drain_start = 1'b0;
                step();
                step();
                check("bp_hold_valid", VW'(o_dma_valid), VW'(1));
                check("bp_hold_addr", VW'(o_dma_addr), VW'(1));
                check("bp_hold_data", o_dma_data, rep(16'd1));
                check("bp_hold_nodone", VW'(o_drain_done), '0);
            end
            accept();
        end
        check("bp_done", VW'(o_drain_done), VW'(1));
        check("bp_done_busy", VW'(o_busy), '0);
        step();
        check("bp_done_pulse", VW'(o_drain_done), '0);
        check("bp_done_count", VW'(done_cnt - done_ref), VW'(1));
        for (int a = 0; a < 4; a++) wr_one(AW'(a), rep(16'h0), 1'b0);
        check("bp_flags_cleared", VW'(o_err), '0);

        // Wait-for-final
        wr_one(6'd0, rep(16'h0010), 1'b1);
        done_ref = done_cnt;
        start_drain(7'd2);
        wait_valid(4, "wf_valid0");
        check("wf_data0", o_dma_data, rep(16'h0010));
        accept();
        repeat (5) step();
        check("wf_scan_valid", VW'(o_dma_valid), '0);
        check("wf_scan_busy", VW'(o_busy), VW'(1));
        wr_one(6'd1, rep(16'h0011), 1'b1);
        wait_valid(1, "wf_valid1");
        check("wf_addr1", VW'(o_dma_addr), VW'(1));
        check("wf_data1", o_dma_data, rep(16'h0011));
        accept();
        check("wf_done", VW'(o_drain_done), VW'(1));
        step();
        check("wf_done_count", VW'(done_cnt - done_ref), VW'(1));

        // count = 0
        start_drain(7'd0);
        check("c0_done", VW'(o_drain_done), VW'(1));
        check("c0_no_valid", VW'(o_dma_valid), '0);
        step();
        check("c0_idle", VW'(o_drain_done | o_busy), '0);

        // count = DEPTH, all entries final, ready held high
        for (int a = 0; a < 64; a++) wr_one(AW'(a), rep(16'(16'h0100 + a)), 1'b1);
        done_ref = done_cnt;
        start_drain(7'd64);
        i_dma_ready = 1'b1;
        for (int e = 0; e < 64; e++) begin
            wait_valid(4, $sformatf("full_valid%0d", e));
            check($sformatf("full_addr%0d", e), VW'(o_dma_addr), VW'(e));
            check($sformatf("full_data%0d", e), o_dma_data, rep(16'(16'h0100 + e)));
            step();
        end
        i_dma_ready = 1'b0;
        check("full_done", VW'(o_drain_done), VW'(1));
        check("full_last_addr", VW'(o_dma_addr), VW'(63));
        step();
        check("full_done_count", VW'(done_cnt - done_ref), VW'(1));
        check("full_err", VW'(o_err), '0);

        // Overwrite of an undrained final entry
        wr_one(6'd2, rep(16'h0222), 1'b1);
        check("err_first_write", VW'(o_err), '0);
        wr_one(6'd2, rep(16'h0333), 1'b0);
        check("err_overwrite", VW'(o_err), VW'(1));
        repeat (3) step();
        check("err_sticky", VW'(o_err), VW'(1));

        // Reset in PRESENT
        wr_one(6'd0, rep(16'h0077), 1'b1);
        start_drain(7'd1);
        wait_valid(4, "rst_mid_valid_pre");
        i_rd_en = 1'b1;
        i_rd_addr = 6'd0;
        step();
        i_rd_en = 1'b0;
        check("rst_mid_rd_valid_pre", VW'(o_rd_valid), VW'(1));
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_dma_valid", VW'(o_dma_valid), '0);
        check("rst_mid_busy", VW'(o_busy), '0);
        check("rst_mid_err", VW'(o_err), '0);
        check("rst_mid_rd_valid", VW'(o_rd_valid), '0);
        check("rst_mid_dma_data", o_dma_data, '0);
        step();
        rst = 1'b0;
        step();
        done_ref = done_cnt;
        start_drain(7'd1);
        repeat (4) step();
        check("rst_flag_wait_valid", VW'(o_dma_valid), '0);
        check("rst_flag_wait_busy", VW'(o_busy), VW'(1));
        check("rst_no_done", VW'(done_cnt - done_ref), '0);

        // Write to the presented entry
        wr_one(6'd0, rep(16'h0055), 1'b1);
        check("pres_err_clean", VW'(o_err), '0);
        wait_valid(2, "pres_valid");
        check("pres_data", o_dma_data, rep(16'h0055));
        wr_one(6'd0, rep(16'h0066), 1'b0);
        check("pres_err", VW'(o_err), VW'(1));
        check("pres_data_stable", o_dma_data, rep(16'h0055));
        check("pres_still_valid", VW'(o_dma_valid), VW'(1));
        accept();
        check("pres_done", VW'(o_drain_done), VW'(1));
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, tests %0d", tests);
        $fatal(1);
    end

endmodule

// File: doc/nbout_buffer.md
Name: nbout_buffer

Overview:
- Output neuron buffer (NBout) that sits on the far side of the NFU pipeline's NBout interface.
- Accepts Tn-wide partial-sum and final-result writes from the pipeline.
- Returns partial sums to the pipeline one cycle after a read request, for NFU-2 accumulation reload.
- Streams completed (final) entries out to the DMA/memory side through a valid/ready drain port, in address order.

Parameters:
- BIT_WIDTH, 16, width of one neuron value.
- Tn, 16, neurons per entry.
- DEPTH, 64, number of entries.
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W.

Ports:
- clk  in  1  main clock
- rst  in  1  asynchronous, active-high reset
- i_wr_en  in  1  pipeline write strobe
- i_wr_addr  in  ADDR_W  write entry index
- i_wr_data  in  BIT_WIDTH*Tn  pipeline result vector
- i_wr_final  in  1  1 = NFU-3 final result, 0 = NFU-2 partial sum
- i_rd_en  in  1  partial-sum reload request
- i_rd_addr  in  ADDR_W  reload entry index
- o_rd_data  out  BIT_WIDTH*Tn  reload data to the pipeline
- o_rd_valid  out  1  o_rd_data valid
- i_drain_start  in  1  start draining entries 0..i_drain_count-1
- i_drain_count  in  ADDR_W+1  number of entries to drain (0..DEPTH)
- o_dma_data  out  BIT_WIDTH*Tn  drained entry
- o_dma_addr  out  ADDR_W  index of the drained entry
- o_dma_valid  out  1  drain data valid
- i_dma_ready  in  1  DMA accepts data
- o_drain_done  out  1  one-cycle pulse when the drain completes
- o_busy  out  1  drain in progress
- o_err  out  1  sticky protocol error

Behaviour:
- Reset: asynchronous, active-high.
  - All outputs 0; FSM to IDLE; all final flags cleared; error cleared.
  - Memory contents are undefined after reset.
  - Reset asserted mid-drain aborts the drain with no o_drain_done pulse.
- Storage: DEPTH x (BIT_WIDTH*Tn) register array with one write port and two read ports (reload, drain), plus a DEPTH-bit final-flag vector.
- Write: on i_wr_en, mem[i_wr_addr] <= i_wr_data and flag[i_wr_addr] <= i_wr_final, both at the clock edge.
- Reload read: registered, latency 1.
  - o_rd_valid follows i_rd_en by one cycle; o_rd_data holds its value when o_rd_valid = 0.
  - If a write and a reload read hit the same address in the same cycle, the write data is bypassed (o_rd_data = i_wr_data).
- Drain FSM states: IDLE, SCAN, PRESENT, DONE.
  - IDLE: on i_drain_start, latch the count and set idx = 0.
    - count = 0: go to DONE.
    - otherwise: go to SCAN, with o_busy = 1.
    - i_drain_start while not in IDLE is ignored.
  - SCAN: if flag[idx] = 1, register mem[idx] into o_dma_data and idx into o_dma_addr, then go to PRESENT. Otherwise stay in SCAN and wait for the final write.
  - PRESENT: o_dma_valid = 1; o_dma_data and o_dma_addr are stable until handshake.
    - On i_dma_ready: clear flag[idx] and increment idx.
    - If idx was the last entry, go to DONE; else go to SCAN.
    - i_dma_ready while o_dma_valid = 0 has no effect.
  - DONE: o_drain_done = 1 for one cycle, o_busy = 0, then go to IDLE.
- Throughput: one entry per 2 cycles at best.
- Simultaneous flag events: a final write to idx in the same cycle as its handshake clear leaves the flag set (write wins).
- o_err is set (sticky until reset) when:
  - a write targets an entry whose flag = 1 (an undrained final result is overwritten), or
  - a write targets o_dma_addr while o_dma_valid = 1.
  - The write is still performed in both cases; the presented o_dma_data does not change.
- Wrap-around: idx never exceeds count-1. A count of DEPTH drains every entry; idx is ADDR_W+1 bits wide internally.

Decomposition:
- Shared package (nbout_pkg):
  - BIT_WIDTH and Tn defaults, common with the NFU pipeline.
  - Drain FSM state encoding (IDLE=0, SCAN=1, PRESENT=2, DONE=3).
  - Entry vector width constant.
- Sub-module nbout_mem: 1W2R register array with the same-address write-bypass on the reload port.
- nbout_buffer holds the flags, the FSM and the error logic.

Test Plan:
- Reset: assert rst mid-cycle while in PRESENT -> o_dma_valid, o_busy, o_err and o_rd_valid go to 0 immediately; the next drain of count=1 waits in SCAN because the flag was cleared.
- Reload: write addr 5 = 0x0001 in every lane (final=0), then read addr 5 next cycle -> o_rd_valid = 1 one cycle later with all lanes 0x0001. Same-cycle write 0x00AA plus read of addr 5 -> returns 0x00AA.
- Drain with backpressure: final writes to addrs 0..3 (lane value = addr), start count=4, hold i_dma_ready = 0 for 3 cycles at entry 1 -> o_dma_data/o_dma_addr stay at 1; four handshakes in order 0..3; o_drain_done pulses once; all flags cleared.
- Wait-for-final: start count=2 with only addr 0 final -> entry 0 drains, FSM waits in SCAN at idx 1; final write to addr 1 -> entry 1 presented within 2 cycles, then o_drain_done.
- Errors: final write to addr 2, then a second write to addr 2 before drain -> o_err = 1 and stays set. Write to o_dma_addr during PRESENT -> o_dma_data unchanged, o_err = 1.
- Boundaries: count=0 -> o_drain_done next cycle with no o_dma_valid. count=64 with all entries final -> 64 handshakes, last o_dma_addr = 63. i_drain_start while busy -> ignored.
